tx_slot_reader: RTL and testbench

//  MAC-side sequencer for the TX slot buffer. It waits for a filled slot and latches its byte size.
//  It issues word-aligned reads with a 1-cycle sync read latency and streams the words to the MAC

---
 rtl/eth_tx_pkg.sv | 8 +
 rtl/tx_slot_reader_out_fifo.sv | 34 +++
 rtl/tx_slot_reader.sv | 125 ++++++++++++
 tb/tb_tx_slot_reader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared state type, slot size and keep-mask helper for the TX slot reader
package eth_tx_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} tx_rd_state_e;
  localparam int eth_tx_slot_bytes_gp = 2048;
  function automatic logic [7:0] keep_mask(input int r, input int b);
    return (r == 0) ? 8'((1 << b) - 1) : 8'((1 << r) - 1);
  endfunction
endpackage

// File: rtl/tx_slot_reader_out_fifo.sv
// tx_slot_reader_out_fifo: 2-entry output FIFO holding {data, keep, last} beats
// Ports: push_v_i/push_data_i write a beat, pop_i removes the head (only when count_o != 0),
// head_o is the oldest beat, count_o is the occupancy used for read credits.
module tx_slot_reader_out_fifo #(
  parameter int width_p = 73
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_v_i,
  input  logic [width_p-1:0] push_data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] head_o,
  output logic [1:0]         count_o
);
  logic [width_p-1:0] mem_q [2];
  logic wr_q, rd_q;
  logic [1:0] count_q;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_v_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      count_q <= count_q + 2'(push_v_i) - 2'(pop_i);
    end
  end
  assign head_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/tx_slot_reader.sv
// tx_slot_reader: streams a filled TX slot from buffer memory to the MAC and dequeues it
// Ports: read_slot_v_i/read_size_i present the head slot, read_slot_ready_and_o dequeues it;
// read_v_o/read_addr_o issue word reads answered on read_data_i one cycle later;
// tx_v_o/tx_ready_and_i handshake tx_data_o/tx_keep_o/tx_last_o to the MAC.
// Define TX_SLOT_READER_STATS_EN to add frames_o/bytes_o counters of dequeued nonzero frames.
module tx_slot_reader
  import eth_tx_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int els_p        = eth_tx_slot_bytes_gp,
  parameter int size_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        read_slot_v_i,
  output logic                        read_slot_ready_and_o,
  input  logic [size_width_p-1:0]     read_size_i,
  output logic                        read_v_o,
  output logic [$clog2(els_p)-1:0]    read_addr_o,
  input  logic [data_width_p-1:0]     read_data_i,
  output logic                        tx_v_o,
  input  logic                        tx_ready_and_i,
  output logic [data_width_p-1:0]     tx_data_o,
  output logic [data_width_p/8-1:0]   tx_keep_o,
  output logic                        tx_last_o
`ifdef TX_SLOT_READER_STATS_EN
  ,
  output logic [31:0]                 frames_o,
  output logic [31:0]                 bytes_o
`endif
);
  localparam int bytes_lp = data_width_p / 8;
  localparam int addr_w_lp = $clog2(els_p);
  localparam int sz_w_lp = addr_w_lp + 1;
  localparam int ent_w_lp = data_width_p + bytes_lp + 1;
  tx_rd_state_e state_q, state_d;
  logic [addr_w_lp-1:0] addr_q, addr_d, last_addr_q, last_addr_d;
  logic [sz_w_lp-1:0] size_q, size_d, clamp;
  logic deq_q, deq_d, inflight_q, inflight_last_q, inflight_last_d;
  logic [1:0] count;
  logic [ent_w_lp-1:0] head, cap, out;
  logic issue, accept, push, pop;
  logic [bytes_lp-1:0] last_keep;
  assign clamp = (32'(read_size_i) > els_p) ? sz_w_lp'(els_p) : sz_w_lp'(read_size_i);
  assign last_keep = bytes_lp'(keep_mask(int'(size_q) % bytes_lp, bytes_lp));
  // Credits: at most two words are either buffered or still coming back from memory.
  assign issue = (state_q == READ) && ({1'b0, count} + {2'b0, inflight_q} < 3'd2);
  assign cap = {read_data_i, inflight_last_q ? last_keep : {bytes_lp{1'b1}}, inflight_last_q};
  // An empty FIFO passes returning read data straight through; it is captured only if not taken.
  assign out = (count != 2'd0) ? head : cap;
  assign tx_v_o = (count != 2'd0) | inflight_q;
  assign {tx_data_o, tx_keep_o, tx_last_o} = tx_v_o ? out : '0;
  assign accept = tx_v_o & tx_ready_and_i;
  assign pop = (count != 2'd0) & tx_ready_and_i;
  assign push = inflight_q & ~((count == 2'd0) & tx_ready_and_i);
  assign read_v_o = issue;
  assign read_addr_o = addr_q;
  assign read_slot_ready_and_o = deq_q & read_slot_v_i;
  assign inflight_last_d = issue && (addr_q == last_addr_q);
  tx_slot_reader_out_fifo #(.width_p(ent_w_lp)) out_fifo (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .push_v_i(push),
    .push_data_i(cap),
    .pop_i(pop),
    .head_o(head),
    .count_o(count)
  );
  // The dequeue pulse is registered, so IDLE skips the slot while deq_q is still high.
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    last_addr_d = last_addr_q;
    size_d = size_q;
    deq_d = 1'b0;
    if (state_q == IDLE && !deq_q && read_slot_v_i) begin
      size_d = clamp;
      addr_d = '0;
      last_addr_d = addr_w_lp'(clamp - sz_w_lp'(1)) & ~addr_w_lp'(bytes_lp - 1);
      deq_d = clamp == '0;
      state_d = (clamp == '0) ? IDLE : READ;
    end
    if (issue) begin
      addr_d = (addr_q == last_addr_q) ? addr_q : addr_q + addr_w_lp'(bytes_lp);
      state_d = (addr_q == last_addr_q) ? DRAIN : READ;
    end
    if (state_q == DRAIN && accept && tx_last_o) begin
      deq_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      last_addr_q <= '0;
      size_q <= '0;
      deq_q <= 1'b0;
      inflight_q <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      last_addr_q <= last_addr_d;
      size_q <= size_d;
      deq_q <= deq_d;
      inflight_q <= issue;
      inflight_last_q <= inflight_last_d;
    end
  end
`ifdef TX_SLOT_READER_STATS_EN
  logic [31:0] frames_q, bytes_q;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      frames_q <= '0;
      bytes_q <= '0;
    end else if (read_slot_ready_and_o && size_q != '0) begin
      frames_q <= frames_q + 32'd1;
      bytes_q <= bytes_q + 32'(size_q);
    end
  end
  assign frames_o = frames_q;
  assign bytes_o = bytes_q;
`endif
endmodule

// File: tb/tb_tx_slot_reader.sv
// tb_tx_slot_reader: randomized scoreboard bench for tx_slot_reader
module tb_tx_slot_reader;
  localparam int B = 8;
  localparam int ELS = 2048;
  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  logic clk = 0, reset_n = 0, slot_v = 0, deq, read_v, tx_v, tx_ready = 0, tx_last;
  logic [15:0] size = 0;
  logic [10:0] read_addr;
  logic [63:0] read_data = 0, tx_data;
  logic [7:0] tx_keep;
  beat_t exp_q[$];
  beat_t prev;
  int vectors = 0, miscompares = 0;
  int cyc = 0, start = 0, last_cyc = 0, words = 0, rd_cnt = 0, acc_cnt = 0, exp_addr = 0;
  int ready_mode = 0;
  int unsigned seed = 0;
  logic frame_active = 0, pending = 0, zero_frame = 0, mon_en = 0, hold = 1, prev_stall = 0;
  always #5 clk = ~clk;
  tx_slot_reader dut (
    .clk_i(clk), .reset_n_i(reset_n), .read_slot_v_i(slot_v), .read_slot_ready_and_o(deq),
    .read_size_i(size), .read_v_o(read_v), .read_addr_o(read_addr), .read_data_i(read_data),
    .tx_v_o(tx_v), .tx_ready_and_i(tx_ready), .tx_data_o(tx_data), .tx_keep_o(tx_keep),
    .tx_last_o(tx_last)
  );
  function automatic logic [63:0] mem_word(input int unsigned s, input int a);
    return {s, 32'(a) * 32'h9E3779B9} ^ 64'h0123_4567_89AB_CDEF;
  endfunction
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (read_v) read_data <= mem_word(seed, int'(read_addr));
  always @(posedge clk) begin
    #1;
    tx_ready = hold ? 1'b0 : ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom % 2) :
               (cyc % 4 == 0 || cyc % 4 == 3);
  end
  always @(negedge clk) begin
    beat_t cur;
    int outst;
    if (mon_en) begin
      cur = '{tx_data, tx_keep, tx_last};
      outst = rd_cnt - acc_cnt;
      chk("read_v", read_v, frame_active && cyc > start && rd_cnt < words && outst < 2);
      if (read_v) begin
        chk("read_addr", read_addr, exp_addr);
        rd_cnt++;
        exp_addr += B;
      end
      if (prev_stall) chk("tx_hold", {tx_v, cur}, {1'b1, prev});
      if (exp_q.size() == 0) chk("tx_idle", tx_v, 0);
      else if (tx_v && tx_ready) begin
        chk("tx_beat", cur, exp_q.pop_front());
        acc_cnt++;
        if (tx_last) last_cyc = cyc;
      end
      prev_stall = tx_v & ~tx_ready;
      prev = cur;
      if (deq) begin
        chk("deq_expected", pending, 1);
        chk("deq_time", cyc, zero_frame ? start + 1 : last_cyc + 1);
        chk("deq_drained", exp_q.size(), 0);
        chk("deq_reads", rd_cnt, words);
        pending = 0;
        frame_active = 0;
      end
    end
  end
  task automatic load_model(input int sz);
    int cl, n, r;
    cl = sz > ELS ? ELS : sz;
    n = (cl + B - 1) / B;
    r = cl % B;
    exp_q.delete();
    for (int i = 0; i < n; i++)
      exp_q.push_back('{mem_word(seed, i * B), (i == n - 1 && r != 0) ? 8'((1 << r) - 1) : 8'hFF, i == n - 1});
    words = n;
    rd_cnt = 0;
    acc_cnt = 0;
    exp_addr = 0;
    prev_stall = 0;
    zero_frame = cl == 0;
    frame_active = cl != 0;
    pending = 1;
    start = cyc;
  endtask
  task automatic start_frame(input int sz, input int mode);
    @(posedge clk);
    #1;
    seed = $urandom;
    ready_mode = mode;
    load_model(sz);
    slot_v = 1;
    size = 16'(sz);
  endtask
  task automatic wait_deq();
    int t = 0;
    while (pending && t < 6000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (pending) begin
      chk("deq_timeout", 0, 1);
      summary();
    end
    @(posedge clk);
    #1;
    slot_v = 0;
  endtask
  task automatic run(input int sz, input int mode);
    start_frame(sz, mode);
    wait_deq();
  endtask
  task automatic reset_mid_frame();
    int t = 0;
    start_frame(64, 0);
    while (acc_cnt < 3 && t < 1000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("beats_before_reset", acc_cnt >= 3, 1);
    hold = 1;
    mon_en = 0;
    @(posedge clk);
    #1;
    reset_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_reset_outs", {read_v, read_addr, tx_v, tx_data, tx_keep, tx_last, deq}, 0);
    @(posedge clk);
    #1;
    reset_n = 1;
    load_model(64);
    hold = 0;
    mon_en = 1;
    wait_deq();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {read_v, read_addr, tx_v, tx_data, tx_keep, tx_last, deq}, 0);
    @(posedge clk);
    #1;
    reset_n = 1;
    hold = 0;
    mon_en = 1;
    run(64, 0);
    run(13, 0);
    run(0, 0);
    run(64, 2);
    run(4000, 1);
    reset_mid_frame();
    for (int i = 0; i < 30; i++) begin
      int sel, sz;
      sel = int'($urandom_range(0, 9));
      sz = sel == 0 ? 0 : sel == 1 ? int'($urandom_range(1900, 5000)) : int'($urandom_range(1, 300));
      run(sz, int'($urandom_range(0, 2)));
    end
    repeat (3) @(posedge clk);
    summary();
  end
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    summary();
  end
endmodule
